regfile_wb_arbiter: RTL and testbench

Write-back controller for the 32x32 integer register file. It shares the file's single write port (A3/WD3/WE3) between the ALU and load/memory write-back requesters using round-robin arbitration with valid/ready handshakes. It also keeps a per-register pending-write scoreboard, which the issue stage uses to detect RAW hazards on RS1/RS2. It sits between the execute/memory stages and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the 32x32 register file: round-robin arbitration of ALU and
// load write-back onto the single write port, plus a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ALU_VALID,
    input  logic [4:0]      ALU_RD,
    input  logic [XLEN-1:0] ALU_DATA,
    output logic            ALU_READY,
    input  logic            MEM_VALID,
    input  logic [4:0]      MEM_RD,
    input  logic [XLEN-1:0] MEM_DATA,
    output logic            MEM_READY,
    input  logic            ISSUE_EN,
    input  logic [4:0]      ISSUE_RD,
    output logic            ISSUE_READY,
    input  logic [4:0]      RS1,
    input  logic [4:0]      RS2,
    output logic            HAZARD,
    output logic [4:0]      A3,
    output logic [XLEN-1:0] WD3,
    output logic            WE3,
    output logic            ERR
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_MEM = 1'b1
    } ptr_t;

    ptr_t            ptr_reg;
    logic [4:0]      a3_reg;
    logic [XLEN-1:0] wd3_reg;
    logic            we3_reg;
    logic            err_reg;

    logic            alu_grant;
    logic            mem_grant;
    logic            accept;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_data;
    logic            issue_fire;
    logic [63:0]     cnt_all;
    logic [31:0]     uflow_vec;
    logic [1:0]      issue_cnt;
    logic [1:0]      rs1_cnt;
    logic [1:0]      rs2_cnt;

    // The pointer only matters when both requesters are valid in the same cycle.
    assign alu_grant = ALU_VALID && (!MEM_VALID || ptr_reg == PTR_ALU);
    assign mem_grant = MEM_VALID && (!ALU_VALID || ptr_reg == PTR_MEM);
    assign accept    = alu_grant || mem_grant;
    assign win_rd    = alu_grant ? ALU_RD : MEM_RD;
    assign win_data  = alu_grant ? ALU_DATA : MEM_DATA;

    assign ALU_READY = alu_grant;
    assign MEM_READY = mem_grant;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ptr_reg <= PTR_ALU;
            a3_reg  <= '0;
            wd3_reg <= '0;
            we3_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            if (ALU_VALID && MEM_VALID) begin
                ptr_reg <= (ptr_reg == PTR_ALU) ? PTR_MEM : PTR_ALU;
            end
            if (accept && win_rd != 5'd0) begin
                a3_reg  <= win_rd;
                wd3_reg <= win_data;
                we3_reg <= 1'b1;
            end else begin
                we3_reg <= 1'b0;
            end
            if (|uflow_vec) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign A3  = a3_reg;
    assign WD3 = wd3_reg;
    assign WE3 = we3_reg;
    assign ERR = err_reg;

    // x0 has no counter; its slot in the flat vector reads as zero pending writes.
    assign cnt_all[1:0] = 2'b00;
    assign uflow_vec[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_cnt
            logic [1:0] cnt_reg;
            logic       inc;
            logic       dec;

            assign inc = issue_fire && (ISSUE_RD == 5'(gi));
            assign dec = we3_reg && (a3_reg == 5'(gi));

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    cnt_reg <= 2'd0;
                end else if (inc && !dec && cnt_reg != 2'd3) begin
                    cnt_reg <= cnt_reg + 2'd1;
                end else if (dec && !inc && cnt_reg != 2'd0) begin
                    cnt_reg <= cnt_reg - 2'd1;
                end
            end

            assign cnt_all[2*gi +: 2] = cnt_reg;
            assign uflow_vec[gi]      = dec && (cnt_reg == 2'd0);
        end
    endgenerate

    assign issue_cnt   = cnt_all[{ISSUE_RD, 1'b0} +: 2];
    assign rs1_cnt     = cnt_all[{RS1, 1'b0} +: 2];
    assign rs2_cnt     = cnt_all[{RS2, 1'b0} +: 2];

    assign ISSUE_READY = (ISSUE_RD == 5'd0) || (issue_cnt != 2'd3);
    assign issue_fire  = ISSUE_EN && ISSUE_READY && (ISSUE_RD != 5'd0);
    assign HAZARD      = (RS1 != 5'd0 && rs1_cnt != 2'd0) ||
                         (RS2 != 5'd0 && rs2_cnt != 2'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scenario bench for regfile_wb_arbiter: expected write-backs are queued when a handshake
// is driven and popped by a monitor whenever WE3 is seen high.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            ALU_VALID, MEM_VALID, ISSUE_EN;
    logic [4:0]      ALU_RD, MEM_RD, ISSUE_RD, RS1, RS2;
    logic [XLEN-1:0] ALU_DATA, MEM_DATA;
    logic            ALU_READY, MEM_READY, ISSUE_READY, HAZARD, WE3, ERR;
    logic [4:0]      A3;
    logic [XLEN-1:0] WD3;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    regfile_wb_arbiter #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
        .MEM_VALID(MEM_VALID), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
        .ISSUE_EN(ISSUE_EN), .ISSUE_RD(ISSUE_RD), .ISSUE_READY(ISSUE_READY),
        .RS1(RS1), .RS2(RS2), .HAZARD(HAZARD),
        .A3(A3), .WD3(WD3), .WE3(WE3), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Scoreboard consumer: every observed write must match the oldest expected one.
    always @(negedge CLK) begin : monitor
        wb_t e;
        if (RST && WE3) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got A3=%0d WD3=%h, required no write", A3, WD3);
            end else begin
                e = exp_q.pop_front();
                if (A3 !== e.rd || WD3 !== e.data) begin
                    errors++;
                    $display("FAIL wb_data: got A3=%0d WD3=%h, required A3=%0d WD3=%h",
                             A3, WD3, e.rd, e.data);
                end else begin
                    $display("wb A3=%0d WD3=%h", A3, WD3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        #2 RST = 1'b0;
        #1 RST = 1'b1;
    endtask

    task automatic test_reset();
        ISSUE_RD = 5'd5; RS1 = 5'd5; RS2 = 5'd31;
        #2;
        checks++;
        if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== '0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: got WE3=%b A3=%0d WD3=%h ERR=%b, required all 0", WE3, A3, WD3, ERR);
        end
        checks++;
        if (HAZARD !== 1'b0 || ISSUE_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_sb: got HAZARD=%b ISSUE_READY=%b, required 0/1", HAZARD, ISSUE_READY);
        end
        #1 RST = 1'b1;
        // Reset in the middle of a live write-back cycle.
        cyc();
        ALU_VALID = 1'b1; ALU_RD = 5'd3; ALU_DATA = 32'hA5A5_0003;
        exp_q.push_back('{rd: 5'd3, data: 32'hA5A5_0003});
        cyc();
        ALU_VALID = 1'b0; RS1 = 5'd3; RS2 = 5'd3; ISSUE_RD = 5'd3;
        @(negedge CLK);
        checks++;
        if (WE3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_we3: got WE3=%b, required 1", WE3);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (WE3 !== 1'b0 || A3 !== 5'd0 || WD3 !== '0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_midcycle: got WE3=%b A3=%0d WD3=%h ERR=%b, required all 0", WE3, A3, WD3, ERR);
        end
        checks++;
        if (HAZARD !== 1'b0 || ISSUE_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_midcycle_sb: got HAZARD=%b ISSUE_READY=%b, required 0/1", HAZARD, ISSUE_READY);
        end
        #1 RST = 1'b1;
    endtask

    task automatic test_single_write();
        cyc();
        ISSUE_EN = 1'b1; ISSUE_RD = 5'd5;
        cyc();
        ISSUE_EN = 1'b0; RS1 = 5'd5; RS2 = 5'd0;
        @(negedge CLK);
        checks++;
        if (HAZARD !== 1'b1) begin
            errors++;
            $display("FAIL single_hazard_set: got HAZARD=%b, required 1", HAZARD);
        end
        cyc();
        ALU_VALID = 1'b1; ALU_RD = 5'd5; ALU_DATA = 32'hDEADBEEF;
        exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        @(negedge CLK);
        checks++;
        if (ALU_READY !== 1'b1 || MEM_READY !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got ALU_READY=%b MEM_READY=%b, required 1/0", ALU_READY, MEM_READY);
        end
        cyc();
        ALU_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd5 || WD3 !== 32'hDEADBEEF || HAZARD !== 1'b1) begin
            errors++;
            $display("FAIL single_wb: got WE3=%b A3=%0d WD3=%h HAZARD=%b, required 1/5/deadbeef/1",
                     WE3, A3, WD3, HAZARD);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (HAZARD !== 1'b0 || WE3 !== 1'b0) begin
            errors++;
            $display("FAIL single_hazard_clear: got HAZARD=%b WE3=%b, required 0/0", HAZARD, WE3);
        end
    endtask

    task automatic test_contention();
        logic exp_alu;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            cyc();
            ISSUE_EN = 1'b1; ISSUE_RD = (i % 2 == 0) ? 5'd1 : 5'd2;
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            ISSUE_EN  = 1'b0;
            ALU_VALID = 1'b1; ALU_RD = 5'd1; ALU_DATA = 32'h11;
            MEM_VALID = 1'b1; MEM_RD = 5'd2; MEM_DATA = 32'h22;
            exp_alu = (i % 2 == 0);
            if (exp_alu) exp_q.push_back('{rd: 5'd1, data: 32'h11});
            else         exp_q.push_back('{rd: 5'd2, data: 32'h22});
            @(negedge CLK);
            checks++;
            if (ALU_READY !== exp_alu || MEM_READY !== !exp_alu) begin
                errors++;
                $display("FAIL contention_grant%0d: got ALU_READY=%b MEM_READY=%b, required %b/%b",
                         i, ALU_READY, MEM_READY, exp_alu, !exp_alu);
            end
        end
        cyc();
        ALU_VALID = 1'b0; MEM_VALID = 1'b0; RS1 = 5'd1; RS2 = 5'd2;
        cyc();
        @(negedge CLK);
        checks++;
        if (HAZARD !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL contention_drain: got HAZARD=%b ERR=%b, required 0/0", HAZARD, ERR);
        end
    endtask

    task automatic test_x0();
        cyc();
        ALU_VALID = 1'b1; ALU_RD = 5'd0; ALU_DATA = 32'hFFFFFFFF;
        @(negedge CLK);
        checks++;
        if (ALU_READY !== 1'b1) begin
            errors++;
            $display("FAIL x0_ready: got ALU_READY=%b, required 1", ALU_READY);
        end
        cyc();
        ALU_VALID = 1'b0; ISSUE_EN = 1'b1; ISSUE_RD = 5'd0;
        @(negedge CLK);
        checks++;
        if (WE3 !== 1'b0 || ISSUE_READY !== 1'b1) begin
            errors++;
            $display("FAIL x0_no_write: got WE3=%b ISSUE_READY=%b, required 0/1", WE3, ISSUE_READY);
        end
        cyc();
        ISSUE_EN = 1'b0; RS1 = 5'd0; RS2 = 5'd0;
        @(negedge CLK);
        checks++;
        if (HAZARD !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL x0_hazard: got HAZARD=%b ERR=%b, required 0/0", HAZARD, ERR);
        end
    endtask

    task automatic test_saturation();
        RS1 = 5'd0; RS2 = 5'd7;
        cyc();
        ISSUE_EN = 1'b1; ISSUE_RD = 5'd7;
        cyc();
        cyc();
        ISSUE_EN = 1'b0;
        ALU_VALID = 1'b1; ALU_RD = 5'd7; ALU_DATA = 32'h70;
        exp_q.push_back('{rd: 5'd7, data: 32'h70});
        @(negedge CLK);
        checks++;
        if (ALU_READY !== 1'b1) begin
            errors++;
            $display("FAIL sat_commit_ready: got ALU_READY=%b, required 1", ALU_READY);
        end
        // Commit and issue to r7 on the same edge: count stays at 2.
        cyc();
        ALU_VALID = 1'b0; ISSUE_EN = 1'b1;
        @(negedge CLK);
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd7 || ISSUE_READY !== 1'b1) begin
            errors++;
            $display("FAIL sat_concurrent: got WE3=%b A3=%0d ISSUE_READY=%b, required 1/7/1", WE3, A3, ISSUE_READY);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (ISSUE_READY !== 1'b1) begin
            errors++;
            $display("FAIL sat_two_pending: got ISSUE_READY=%b, required 1", ISSUE_READY);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (ISSUE_READY !== 1'b0) begin
            errors++;
            $display("FAIL sat_full: got ISSUE_READY=%b, required 0", ISSUE_READY);
        end
        cyc();
        ISSUE_EN = 1'b0;
        @(negedge CLK);
        checks++;
        if (ISSUE_READY !== 1'b0 || HAZARD !== 1'b1) begin
            errors++;
            $display("FAIL sat_fourth_ignored: got ISSUE_READY=%b HAZARD=%b, required 0/1", ISSUE_READY, HAZARD);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            MEM_VALID = 1'b1; MEM_RD = 5'd7; MEM_DATA = 32'h71 + 32'(i);
            exp_q.push_back('{rd: 5'd7, data: 32'h71 + 32'(i)});
            @(negedge CLK);
            checks++;
            if (MEM_READY !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got MEM_READY=%b, required 1", i, MEM_READY);
            end
        end
        cyc();
        MEM_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (HAZARD !== 1'b1) begin
            errors++;
            $display("FAIL sat_one_left: got HAZARD=%b, required 1", HAZARD);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (HAZARD !== 1'b0 || ISSUE_READY !== 1'b1 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL sat_drained: got HAZARD=%b ISSUE_READY=%b ERR=%b, required 0/1/0", HAZARD, ISSUE_READY, ERR);
        end
    endtask

    task automatic test_underflow();
        pulse_reset();
        cyc();
        MEM_VALID = 1'b1; MEM_RD = 5'd9; MEM_DATA = 32'h99;
        exp_q.push_back('{rd: 5'd9, data: 32'h99});
        @(negedge CLK);
        checks++;
        if (MEM_READY !== 1'b1 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL uflow_accept: got MEM_READY=%b ERR=%b, required 1/0", MEM_READY, ERR);
        end
        cyc();
        MEM_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (WE3 !== 1'b1 || A3 !== 5'd9 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL uflow_write: got WE3=%b A3=%0d ERR=%b, required 1/9/0", WE3, A3, ERR);
        end
        cyc();
        @(negedge CLK);
        checks++;
        if (ERR !== 1'b1) begin
            errors++;
            $display("FAIL uflow_err_set: got ERR=%b, required 1", ERR);
        end
        repeat (3) cyc();
        @(negedge CLK);
        checks++;
        if (ERR !== 1'b1) begin
            errors++;
            $display("FAIL uflow_err_sticky: got ERR=%b, required 1", ERR);
        end
        pulse_reset();
        #1;
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL uflow_err_reset: got ERR=%b, required 0", ERR);
        end
    endtask

    initial begin
        ALU_VALID = 1'b0; ALU_RD = '0; ALU_DATA = '0;
        MEM_VALID = 1'b0; MEM_RD = '0; MEM_DATA = '0;
        ISSUE_EN = 1'b0; ISSUE_RD = '0; RS1 = '0; RS2 = '0;
        test_reset();
        test_single_write();
        test_contention();
        test_x0();
        test_saturation();
        test_underflow();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wb_missing: got %0d writes never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
